reorder_buffer: RTL

- In-order commit buffer sitting directly upstream of the architectural register file.
- Allocates one tagged entry per dispatched instruction and captures results broadcast on the common data bus (CDB).
- Retires at most one completed head entry per cycle; the registered commit outputs drive the register file write port (is_writing_rd / rd_reg_id / rd_val) directly.
- Provides two combinational operand-query ports for dispatch.

---
 rtl/reorder_buffer_if.sv | 44 ++++
 rtl/reorder_buffer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch, CDB, operand-query and commit signals of the reorder buffer.
// master: dispatch/CDB/register-file side; slave: the reorder buffer itself.
interface reorder_buffer_if #(
    parameter int ROB_SIZE_WIDTH = 3
);
    logic                      rdy_in;
    logic                      flush_pipline;
    logic                      issue_valid;
    logic                      issue_has_rd;
    logic [4:0]                issue_rd_id;
    logic                      issue_ready;
    logic [31:0]               issue_val;
    logic [ROB_SIZE_WIDTH-1:0] issue_rob_id;
    logic                      rob_full;
    logic                      rob_empty;
    logic                      cdb_valid;
    logic [ROB_SIZE_WIDTH-1:0] cdb_rob_id;
    logic [31:0]               cdb_val;
    logic [ROB_SIZE_WIDTH-1:0] q1_rob_id;
    logic                      q1_ready;
    logic [31:0]               q1_val;
    logic [ROB_SIZE_WIDTH-1:0] q2_rob_id;
    logic                      q2_ready;
    logic [31:0]               q2_val;
    logic                      commit_valid;
    logic [ROB_SIZE_WIDTH-1:0] commit_rob_id;
    logic                      is_writing_rd;
    logic [4:0]                rd_reg_id;
    logic [31:0]               rd_val;

    modport master (
        output rdy_in, flush_pipline, issue_valid, issue_has_rd, issue_rd_id, issue_ready, issue_val,
               cdb_valid, cdb_rob_id, cdb_val, q1_rob_id, q2_rob_id,
        input  issue_rob_id, rob_full, rob_empty, q1_ready, q1_val, q2_ready, q2_val,
               commit_valid, commit_rob_id, is_writing_rd, rd_reg_id, rd_val
    );

    modport slave (
        input  rdy_in, flush_pipline, issue_valid, issue_has_rd, issue_rd_id, issue_ready, issue_val,
               cdb_valid, cdb_rob_id, cdb_val, q1_rob_id, q2_rob_id,
        output issue_rob_id, rob_full, rob_empty, q1_ready, q1_val, q2_ready, q2_val,
               commit_valid, commit_rob_id, is_writing_rd, rd_reg_id, rd_val
    );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit buffer feeding the architectural register file write port.
// Ports: clk_in clock; rst_in sync active-high reset; bus (slave) carries ready/flush,
// dispatch allocation, CDB broadcast, two operand queries and registered commit outputs.
module reorder_buffer #(
    parameter int ROB_SIZE_WIDTH = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    reorder_buffer_if.slave  bus
);
    localparam int DEPTH = 1 << ROB_SIZE_WIDTH;
    localparam int W = ROB_SIZE_WIDTH;

    logic [W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [W:0]     count_q, count_d;
    logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d, has_rd_q, has_rd_d;
    logic [4:0]     rd_id_q [DEPTH];
    logic [4:0]     rd_id_d [DEPTH];
    logic [31:0]    val_q [DEPTH];
    logic [31:0]    val_d [DEPTH];
    logic           commit_valid_q, commit_valid_d, is_writing_q, is_writing_d;
    logic [W-1:0]   commit_id_q, commit_id_d;
    logic [4:0]     rd_reg_q, rd_reg_d;
    logic [31:0]    rd_val_q, rd_val_d;
    logic           alloc, commit, q1_byp, q2_byp;

    // count never exceeds DEPTH, so its top bit alone marks a full buffer
    assign bus.rob_full     = count_q[W];
    assign bus.rob_empty    = count_q == '0;
    assign bus.issue_rob_id = tail_q;
    assign alloc  = bus.issue_valid && !bus.rob_full;
    assign commit = busy_q[head_q] && ready_q[head_q];

    // a result broadcast this cycle is forwarded to dispatch before it is stored
    assign q1_byp       = bus.cdb_valid && bus.cdb_rob_id == bus.q1_rob_id;
    assign q2_byp       = bus.cdb_valid && bus.cdb_rob_id == bus.q2_rob_id;
    assign bus.q1_ready = busy_q[bus.q1_rob_id] && (q1_byp || ready_q[bus.q1_rob_id]);
    assign bus.q2_ready = busy_q[bus.q2_rob_id] && (q2_byp || ready_q[bus.q2_rob_id]);
    assign bus.q1_val   = !busy_q[bus.q1_rob_id] ? '0 : q1_byp ? bus.cdb_val : val_q[bus.q1_rob_id];
    assign bus.q2_val   = !busy_q[bus.q2_rob_id] ? '0 : q2_byp ? bus.cdb_val : val_q[bus.q2_rob_id];

    assign bus.commit_valid  = commit_valid_q;
    assign bus.commit_rob_id = commit_id_q;
    assign bus.is_writing_rd = is_writing_q;
    assign bus.rd_reg_id     = rd_reg_q;
    assign bus.rd_val        = rd_val_q;

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        busy_d         = busy_q;
        ready_d        = ready_q;
        has_rd_d       = has_rd_q;
        rd_id_d        = rd_id_q;
        val_d          = val_q;
        commit_valid_d = commit_valid_q;
        is_writing_d   = is_writing_q;
        commit_id_d    = commit_id_q;
        rd_reg_d       = rd_reg_q;
        rd_val_d       = rd_val_q;
        if (bus.rdy_in && bus.flush_pipline) begin
            head_d         = '0;
            tail_d         = '0;
            count_d        = '0;
            busy_d         = '0;
            commit_valid_d = 1'b0;
            is_writing_d   = 1'b0;
        end else if (bus.rdy_in) begin
            if (bus.cdb_valid && busy_q[bus.cdb_rob_id]) begin
                ready_d[bus.cdb_rob_id] = 1'b1;
                val_d[bus.cdb_rob_id]   = bus.cdb_val;
            end
            commit_valid_d = commit;
            is_writing_d   = commit && has_rd_q[head_q] && rd_id_q[head_q] != 5'd0;
            if (commit) begin
                busy_d[head_q] = 1'b0;
                head_d         = head_q + W'(1);
                commit_id_d    = head_q;
                rd_reg_d       = rd_id_q[head_q];
                rd_val_d       = val_q[head_q];
            end
            // tail only equals a busy head when full, and then alloc is blocked
            if (alloc) begin
                busy_d[tail_q]   = 1'b1;
                ready_d[tail_q]  = bus.issue_ready;
                has_rd_d[tail_q] = bus.issue_has_rd;
                rd_id_d[tail_q]  = bus.issue_rd_id;
                val_d[tail_q]    = bus.issue_val;
                tail_d           = tail_q + W'(1);
            end
            count_d = count_q + (W+1)'(alloc) - (W+1)'(commit);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            busy_q         <= '0;
            ready_q        <= '0;
            has_rd_q       <= '0;
            commit_valid_q <= 1'b0;
            is_writing_q   <= 1'b0;
            commit_id_q    <= '0;
            rd_reg_q       <= '0;
            rd_val_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_id_q[i] <= '0;
                val_q[i]   <= '0;
            end
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            has_rd_q       <= has_rd_d;
            commit_valid_q <= commit_valid_d;
            is_writing_q   <= is_writing_d;
            commit_id_q    <= commit_id_d;
            rd_reg_q       <= rd_reg_d;
            rd_val_q       <= rd_val_d;
            rd_id_q        <= rd_id_d;
            val_q          <= val_d;
        end
    end
endmodule
